// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word-addressed RAM plus MMIO status, TX byte FIFO and counters.
// Define DMEM_COUNTERS_EN to build the cycle/instruction counters at MMIO 0x10/0x14/0x18.
module dmem_mmio_responder #(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_adrM,
  input  logic [31:0] mem_wdataM,
  input  logic [3:0]  wea,
  input  logic        instr_stop,
  output logic [31:0] din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int RAM_DEPTH  = 1 << RAM_AW;

  logic              isRam;
  logic              isMmio;
  logic              anyWr;
  logic [7:0]        offset;
  logic [RAM_AW-1:0] ramIdx;

  logic [31:0] ram [RAM_DEPTH];
  logic [7:0]  fifoMem [FIFO_DEPTH];

  logic [FIFO_AW:0] wrPtr_q, wrPtr_d;
  logic [FIFO_AW:0] rdPtr_q, rdPtr_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      din_q, din_d;

  logic full;
  logic empty;
  logic deq;
  logic enqReq;
  logic enqOk;
  logic statusWr;

  logic unusedAdrBits;
  assign unusedAdrBits = ^mem_adrM[27:RAM_AW+2];

  assign isRam    = (mem_adrM[31:28] == 4'h1);
  assign isMmio   = (mem_adrM[31:28] == 4'h8);
  assign anyWr    = |wea;
  assign offset   = mem_adrM[7:0];
  assign ramIdx   = mem_adrM[RAM_AW+1:2];

  assign empty    = (wrPtr_q == rdPtr_q);
  assign full     = (wrPtr_q[FIFO_AW] != rdPtr_q[FIFO_AW]) &&
                    (wrPtr_q[FIFO_AW-1:0] == rdPtr_q[FIFO_AW-1:0]);
  assign deq      = ~empty & tx_ready;
  assign enqReq   = isMmio & anyWr & (offset == 8'h08);
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign enqOk    = enqReq & (~full | deq);
  assign statusWr = isMmio & anyWr & (offset == 8'h00);

  assign tx_valid = ~empty;
  assign tx_data  = empty ? 8'h00 : fifoMem[rdPtr_q[FIFO_AW-1:0]];
  assign din      = din_q;

`ifdef DMEM_COUNTERS_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instr_q, instr_d;
  logic        clrWr;

  assign clrWr = isMmio & anyWr & (offset == 8'h18);

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    instr_d = instr_stop ? instr_q : instr_q + 32'd1;
    if (clrWr) begin
      cycle_d = 32'd0;
      instr_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end
`else
  logic unusedStop;
  assign unusedStop = instr_stop;
`endif

  always_comb begin
    wrPtr_d = enqOk ? wrPtr_q + (FIFO_AW+1)'(1) : wrPtr_q;
    rdPtr_d = deq   ? rdPtr_q + (FIFO_AW+1)'(1) : rdPtr_q;
    ovf_d   = ovf_q;
    if (statusWr) begin
      ovf_d = 1'b0;
    end else if (enqReq && full && !deq) begin
      ovf_d = 1'b1;
    end

    din_d = 32'd0;
    if (isRam) begin
      din_d = ram[ramIdx];
    end else if (isMmio) begin
      case (offset)
        8'h00: din_d = {29'd0, ovf_q, empty, ~full};
`ifdef DMEM_COUNTERS_EN
        8'h10: din_d = cycle_q;
        8'h14: din_d = instr_q;
`endif
        default: din_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      ovf_q   <= 1'b0;
      din_q   <= 32'd0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      ovf_q   <= ovf_d;
      din_q   <= din_d;
    end
  end

  // Storage arrays carry no reset; the read above sees the pre-edge word (read-first)
  always_ff @(posedge clk) begin
    if (isRam) begin
      for (int i = 0; i < 4; i++) begin
        if (wea[i]) begin
          ram[ramIdx][8*i +: 8] <= mem_wdataM[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enqOk) begin
      fifoMem[wrPtr_q[FIFO_AW-1:0]] <= mem_wdataM[7:0];
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model (RAM map, byte queue, counters).
module tb_dmem_mmio_responder;

  localparam int RAM_AW = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_adrM = 32'h3000_0000;
  logic [31:0] mem_wdataM = 32'd0;
  logic [3:0]  wea = 4'd0;
  logic        instr_stop = 1'b0;
  logic [31:0] din;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  dmem_mmio_responder #(.RAM_AW(RAM_AW), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .mem_adrM(mem_adrM), .mem_wdataM(mem_wdataM), .wea(wea),
    .instr_stop(instr_stop), .din(din), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;
  bit checkEn = 1'b0;

  // Reference state: RAM words by index, TX bytes in arrival order, sticky overflow, counters
  logic [31:0] mRam [int];
  logic [7:0]  mQ [$];
  logic        mOvf = 1'b0;
  logic [31:0] mCyc = 32'd0;
  logic [31:0] mInstr = 32'd0;
  logic [31:0] mDin = 32'd0;
  logic [7:0]  drained [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] r;
    int idx;
    r = 32'd0;
    idx = int'(a[RAM_AW+1:2]);
    if (a[31:28] == 4'h1) begin
      r = mRam.exists(idx) ? mRam[idx] : 32'd0;
    end else if (a[31:28] == 4'h8) begin
      case (a[7:0])
        8'h00: r = {29'd0, mOvf, (mQ.size() == 0), (mQ.size() != 8)};
`ifdef DMEM_COUNTERS_EN
        8'h10: r = mCyc;
        8'h14: r = mInstr;
`endif
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  task automatic modelUpdate(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we,
                             input logic stop, input logic ready);
    logic [31:0] rd;
    logic [31:0] word;
    bit deq, wasFull, mmWr;
    int idx;
    rd      = modelRead(a);
    deq     = (mQ.size() != 0) && ready;
    wasFull = (mQ.size() == 8);
    mmWr    = (a[31:28] == 4'h8) && (we != 4'd0);
    if (a[31:28] == 4'h1 && we != 4'd0) begin
      idx  = int'(a[RAM_AW+1:2]);
      word = mRam.exists(idx) ? mRam[idx] : 32'd0;
      for (int b = 0; b < 4; b++) if (we[b]) word[8*b +: 8] = w[8*b +: 8];
      mRam[idx] = word;
    end
    if (mmWr && a[7:0] == 8'h00) mOvf = 1'b0;
    if (deq) void'(mQ.pop_front());
    if (mmWr && a[7:0] == 8'h08) begin
      if (!wasFull || deq) mQ.push_back(w[7:0]);
      else mOvf = 1'b1;
    end
`ifdef DMEM_COUNTERS_EN
    if (mmWr && a[7:0] == 8'h18) begin
      mCyc   = 32'd0;
      mInstr = 32'd0;
    end else begin
      mCyc = mCyc + 32'd1;
      if (!stop) mInstr = mInstr + 32'd1;
    end
`endif
    mDin = rd;
  endtask

  task automatic modelReset();
    mQ.delete();
    mOvf   = 1'b0;
    mCyc   = 32'd0;
    mInstr = 32'd0;
    mDin   = 32'd0;
  endtask

  // One bus cycle: drive at posedge+1, model advances after the negedge compare, return at posedge+1
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we,
                               input logic stop, input logic ready);
    mem_adrM   = a;
    mem_wdataM = w;
    wea        = we;
    instr_stop = stop;
    tx_ready   = ready;
    if (tx_valid && ready) drained.push_back(tx_data);
    @(negedge clk);
    #1;
    modelUpdate(a, w, we, stop, ready);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("reset din", din, 32'd0);
    checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset tx_data", 32'(tx_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drainInto(input int steps);
    drained.delete();
    for (int i = 0; i < steps; i++) applyStimulus(32'h3000_0000, 32'd0, 4'd0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cycle din", din, mDin);
      checkOutput("cycle tx_valid", 32'(tx_valid), (mQ.size() != 0) ? 32'd1 : 32'd0);
      checkOutput("cycle tx_data", 32'(tx_data), (mQ.size() != 0) ? 32'(mQ[0]) : 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] expT4 [8];
    logic [31:0] a, w;
    logic [3:0] we, rgn;
    logic [7:0] offs [10];
    int readyPct;

    expT4 = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h5A};
    offs  = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h04, 8'h08};

    @(posedge clk);
    #1;
    doReset();
    checkEn = 1'b1;

    for (int i = 0; i < 16; i++) applyStimulus(32'h1000_0000 + 32'(i * 4), 32'd0, 4'hF, 1'b0, 1'b0);

    // RAM byte-lane merge
    applyStimulus(32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    applyStimulus(32'h1000_0010, 32'h0000_5500, 4'b0010, 1'b0, 1'b0);
    applyStimulus(32'h1000_0010, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("T1 merged word", din, 32'hDEAD_55EF);

    // Read-first on a same-cycle write
    applyStimulus(32'h1000_0020, 32'h1111_1111, 4'hF, 1'b0, 1'b0);
    checkOutput("T2 old word", din, 32'h0);
    applyStimulus(32'h1000_0020, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("T2 new word", din, 32'h1111_1111);

    // Overflow on the ninth byte, then in-order drain
    for (int i = 0; i < 9; i++) applyStimulus(32'h8000_0008, 32'h41 + 32'(i), 4'h1, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("T3 status full+ovf", din, 32'h4);
    drainInto(12);
    checkOutput("T3 drained count", 32'(drained.size()), 32'd8);
    for (int i = 0; i < 8 && i < drained.size(); i++)
      checkOutput("T3 drained byte", 32'(drained[i]), 32'h41 + 32'(i));
    applyStimulus(32'h8000_0000, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("T3 status empty+ovf", din, 32'h7);
    applyStimulus(32'h8000_0000, 32'd0, 4'hF, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("T3 status ovf cleared", din, 32'h3);

    // Enqueue into a full FIFO while the head leaves
    for (int i = 0; i < 8; i++) applyStimulus(32'h8000_0008, 32'h61 + 32'(i), 4'h1, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("T4 status full", din, 32'h0);
    applyStimulus(32'h8000_0008, 32'h5A, 4'h1, 1'b0, 1'b1);
    applyStimulus(32'h8000_0000, 32'd0, 4'd0, 1'b0, 1'b0);
    checkOutput("T4 status still full", din, 32'h0);
    drainInto(12);
    checkOutput("T4 drained count", 32'(drained.size()), 32'd8);
    for (int i = 0; i < 8 && i < drained.size(); i++)
      checkOutput("T4 drained byte", 32'(drained[i]), 32'(expT4[i]));

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) applyStimulus(32'h8000_0008, 32'h70 + 32'(i), 4'h1, 1'b0, 1'b0);
    applyStimulus(32'h1000_0010, 32'd0, 4'd0, 1'b0, 1'b1);
    checkOutput("T6 pre din", din, 32'hDEAD_55EF);
    checkOutput("T6 pre tx_valid", 32'(tx_valid), 32'd1);
    doReset();

    // Counters from reset: 100 cycles, 30 with instr_stop high
    for (int i = 0; i < 100; i++) applyStimulus(32'h3000_0000, 32'd0, 4'd0, (i % 10) < 3, 1'b0);
    applyStimulus(32'h8000_0014, 32'd0, 4'd0, 1'b0, 1'b0);
`ifdef DMEM_COUNTERS_EN
    checkOutput("T5 instr count", din, 32'd70);
`else
    checkOutput("T5 instr count absent", din, 32'd0);
`endif
    applyStimulus(32'h8000_0018, 32'd0, 4'hF, 1'b0, 1'b0);
    applyStimulus(32'h3000_0000, 32'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0010, 32'd0, 4'd0, 1'b0, 1'b0);
`ifdef DMEM_COUNTERS_EN
    checkOutput("T5 cycle after clear", din, 32'd1);
`else
    checkOutput("T5 cycle absent", din, 32'd0);
`endif

    // Randomized traffic with shifting consumer back-pressure
    readyPct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: readyPct = 10;
          1: readyPct = 50;
          default: readyPct = 90;
        endcase
      end
      w  = $urandom;
      we = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'h1000_0000 | ($urandom & 32'h0FFF_F000) | (32'($urandom_range(0, 15)) << 2);
        4, 5, 6: begin
          a = 32'h8000_0000 | ($urandom & 32'h0FFF_FF00) | 32'(offs[$urandom_range(0, 9)]);
          if (a[7:0] == 8'h18 && $urandom_range(0, 3) != 0) we = 4'd0;
        end
        default: begin
          rgn = 4'($urandom);
          if (rgn == 4'h1 || rgn == 4'h8) rgn = 4'h2;
          a = {rgn, 28'($urandom)};
        end
      endcase
      applyStimulus(a, w, we, 1'($urandom), $urandom_range(0, 99) < readyPct);
    end

    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
